cond_sink_mc: RTL and testbench

Clocked, multi-channel successor to the single-output conditional sink: joins a data token with a control token and either routes the data to one of `K` output channels or discards it. Control tokens are buffered in a small FIFO so the steering source can run ahead of the data path. It sits between a data producer and a bank of consumers wherever a conditional drop or a conditional fan-out is needed in the synchronous domain.

---
 rtl/cond_sink_mc_pkg.sv | 26 ++
 rtl/cond_sink_mc_if.sv | 38 +++
 rtl/cond_sink_mc_ctl_fifo.sv | 55 +++++
 rtl/cond_sink_mc.sv | 118 +++++++++++
 tb/tb_cond_sink_mc.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cond_sink_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_pkg
// Description : Shared helpers for the multi-channel conditional sink:
//               select-width sizing, discard select code, one-hot decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

  // Width of a select able to encode K channels plus the discard code.
  function automatic int unsigned sel_w(input int unsigned k);
    return $clog2(k + 1);
  endfunction

  // Select value that means "discard" for a K-channel sink.
  function automatic int unsigned SEL_DISCARD(input int unsigned k);
    return k;
  endfunction

  // One bit of a one-hot decode: true when bit position idx is the selected one.
  function automatic logic onehot(input int unsigned sel, input int unsigned idx);
    return sel == idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cond_sink_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_sink_mc_if
// Description : Data, control and output-channel handshakes of the
//               multi-channel conditional sink. master = environment side,
//               slave = sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_sink_mc_if #(
  parameter int N = 32,
  parameter int K = 2
);
  import cond_pkg::*;

  localparam int SW = sel_w(K);

  logic          r_i;
  logic          a_i;
  logic [N-1:0]  d_i;
  logic          r_c;
  logic          a_c;
  logic [SW-1:0] ctl;
  logic [K-1:0]  r_o;
  logic [K-1:0]  a_o;
  logic [N-1:0]  d_o;

  modport master (
    output r_i, d_i, r_c, ctl, a_o,
    input  a_i, a_c, r_o, d_o
  );

  modport slave (
    input  r_i, d_i, r_c, ctl, a_o,
    output a_i, a_c, r_o, d_o
  );

endinterface
`default_nettype wire

// File: rtl/cond_sink_mc_ctl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ctl_fifo
// Description : Synchronous control-token FIFO, first-word-fall-through head,
//               pointers one bit wider than the index for full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ctl_fifo #(
  parameter int W = 2,
  parameter int D = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_push,
  input  wire logic [W-1:0] i_push_data,
  input  wire logic         i_pop,
  output logic      [W-1:0] o_head,
  output logic              o_nonempty,
  output logic              o_full
);

  localparam int AW = $clog2(D);

  logic [W-1:0] r_mem [D];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_nonempty = (r_wptr != r_rptr);
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head     = r_mem[r_rptr[AW-1:0]];
  assign w_do_push  = i_push & ~o_full;
  assign w_do_pop   = i_pop & o_nonempty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cond_sink_mc.sv
`default_nettype none
// ============================================================================
// Module      : cond_sink_mc
// Description : Joins a data token with a buffered control token and either
//               routes the data to one of K output channels through a single
//               output register or discards it. Optional drop counter is
//               built when COND_SINK_DROP_CNT_EN is defined; otherwise
//               drop_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_sink_mc #(
  parameter int N  = 32,
  parameter int K  = 2,
  parameter int D  = 4,
  parameter int CW = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  cond_sink_mc_if.slave bus,
  output logic [CW-1:0] drop_cnt,
  output logic          err
);
  import cond_pkg::*;

  localparam int            SW            = sel_w(K);
  localparam logic [SW-1:0] c_sel_discard = SW'(SEL_DISCARD(K));

  logic [SW-1:0] w_head;
  logic          w_nonempty;
  logic          w_full;
  logic          w_push;
  logic          w_xfer;
  logic          w_discard;
  logic          w_illegal;
  logic          w_drain;
  logic          w_stage_free;
  logic [K-1:0]  w_r_o;

  logic          r_ov;
  logic [SW-1:0] r_osel;
  logic [N-1:0]  r_d_o;
  logic          r_err;

  ctl_fifo #(
    .W (SW),
    .D (D)
  ) u_ctl_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (bus.ctl),
    .i_pop       (w_xfer),
    .o_head      (w_head),
    .o_nonempty  (w_nonempty),
    .o_full      (w_full)
  );

  for (genvar k = 0; k < K; k++) begin : g_onehot
    assign w_r_o[k] = r_ov & onehot(32'(r_osel), k);
  end

  // Join: data is taken only when control is present and either it will be
  // discarded or the output register is free (possibly draining this cycle).
  assign bus.a_c    = ~w_full;
  assign w_push     = bus.r_c & ~w_full;
  assign w_discard  = (w_head >= c_sel_discard);
  assign w_illegal  = (w_head >  c_sel_discard);
  assign w_drain    = |(w_r_o & bus.a_o);
  assign w_stage_free = ~r_ov | w_drain;
  assign bus.a_i    = w_nonempty & bus.r_i & (w_discard | w_stage_free);
  assign w_xfer     = bus.r_i & bus.a_i;
  assign bus.r_o    = w_r_o;
  assign bus.d_o    = r_d_o;
  assign err        = r_err;

  // Output register: load on a routed transfer, empty on drain without reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov   <= 1'b0;
      r_osel <= '0;
      r_d_o  <= '0;
    end else if (w_xfer && !w_discard) begin
      r_ov   <= 1'b1;
      r_osel <= w_head;
      r_d_o  <= bus.d_i;
    end else if (w_drain) begin
      r_ov   <= 1'b0;
    end
  end

  // Sticky flag for discards carrying a select beyond the discard code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_xfer && w_illegal) begin
      r_err <= 1'b1;
    end
  end

`ifdef COND_SINK_DROP_CNT_EN
  logic [CW-1:0] r_drop_cnt;

  // Saturating count of discarded tokens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_xfer && w_discard && (r_drop_cnt != {CW{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CW'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_sink_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_sink_mc
// Description : Self-checking bench for cond_sink_mc (K=3, N=8, D=4, CW=4)
//               plus a K=2 instance for illegal selects. A queue-based
//               reference model is compared every cycle; directed scenarios
//               add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_sink_mc;
  import cond_pkg::*;

  localparam int N  = 8;
  localparam int K  = 3;
  localparam int D  = 4;
  localparam int CW = 4;

`ifdef COND_SINK_DROP_CNT_EN
  localparam int DROP1 = 1;
  localparam int SAT   = 15;
`else
  localparam int DROP1 = 0;
  localparam int SAT   = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cond_sink_mc_if #(.N(N), .K(K)) bus ();
  cond_sink_mc_if #(.N(N), .K(2)) bus2 ();

  logic [CW-1:0] drop_cnt, drop_cnt2;
  logic          err, err2;

  cond_sink_mc #(.N(N), .K(K), .D(D), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .drop_cnt(drop_cnt), .err(err)
  );

  cond_sink_mc #(.N(N), .K(2), .D(D), .CW(CW)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .drop_cnt(drop_cnt2), .err(err2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (K=3 instance) ----------------
  int         mq[$];
  bit         m_ov;
  int         m_sel;
  logic [7:0] m_d;
  int         m_cnt;
  bit         m_err;
  bit         m_valid = 0;

  always @(negedge clk) begin
    bit         exp_ai, exp_ac, drain, push;
    int         h;
    logic [K-1:0] exp_ro;
    exp_ro = m_ov ? K'(1 << m_sel) : '0;
    exp_ac = (mq.size() < D);
    exp_ai = (mq.size() > 0) && bus.r_i && ((mq[0] >= K) || !m_ov || bus.a_o[m_sel]);
    if (m_valid) begin
      check("a_c", 32'(bus.a_c), 32'(exp_ac));
      check("a_i", 32'(bus.a_i), 32'(exp_ai));
      check("r_o", 32'(bus.r_o), 32'(exp_ro));
      check("d_o", 32'(bus.d_o), 32'(m_d));
      check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
      check("err", 32'(err), 32'(m_err));
    end
    if (rst) begin
      mq.delete();
      m_ov = 0; m_sel = 0; m_d = '0; m_cnt = 0; m_err = 0;
      m_valid = 1;
    end else if (m_valid) begin
      drain = m_ov && bus.a_o[m_sel];
      push  = bus.r_c && exp_ac;
      if (exp_ai) begin
        h = mq.pop_front();
        if (h >= K) begin
`ifdef COND_SINK_DROP_CNT_EN
          if (m_cnt < (1 << CW) - 1) m_cnt++;
`endif
          if (h > K) m_err = 1;
          if (drain) m_ov = 0;
        end else begin
          m_ov = 1; m_sel = h; m_d = bus.d_i;
        end
      end else if (drain) begin
        m_ov = 0;
      end
      if (push) mq.push_back(int'(bus.ctl));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.r_i = 0; bus.d_i = '0; bus.r_c = 0; bus.ctl = '0; bus.a_o = '0;
    bus2.r_i = 0; bus2.d_i = '0; bus2.r_c = 0; bus2.ctl = '0; bus2.a_o = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    step(); step();
    rst = 0;

    // Reset mid-operation: token in output register, two controls queued.
    do_reset();
    bus.r_c = 1; bus.ctl = 0; step();
    bus.ctl = 1; step();
    bus.ctl = 2; step();
    bus.r_c = 0; bus.r_i = 1; bus.d_i = 8'h77; step();
    bus.r_i = 0; rst = 1;
    @(negedge clk); check("rst_pre_ro", 32'(bus.r_o), 32'h1);
    step();
    rst = 0;
    @(negedge clk);
    check("rst_ro", 32'(bus.r_o), 32'h0);
    check("rst_ac", 32'(bus.a_c), 32'h1);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_do", 32'(bus.d_o), 32'h0);
    bus.r_i = 1; bus.d_i = 8'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("rst_no_ai", 32'(bus.a_i), 32'h0);
      step();
    end
    idle();

    // Routing at full rate.
    do_reset();
    bus.a_o = 3'b111;
    bus.r_c = 1; bus.ctl = 0; step();
    bus.ctl = 1; step();
    bus.ctl = 2; step();
    bus.r_c = 0; bus.r_i = 1; bus.d_i = 8'h11;
    @(negedge clk); check("route_ai", 32'(bus.a_i), 32'h1);
    step(); bus.d_i = 8'h22;
    @(negedge clk); check("route_ro0", 32'(bus.r_o), 32'h1); check("route_do0", 32'(bus.d_o), 32'h11);
    step(); bus.d_i = 8'h33;
    @(negedge clk); check("route_ro1", 32'(bus.r_o), 32'h2); check("route_do1", 32'(bus.d_o), 32'h22);
    step(); bus.r_i = 0;
    @(negedge clk); check("route_ro2", 32'(bus.r_o), 32'h4); check("route_do2", 32'(bus.d_o), 32'h33);
    step();
    @(negedge clk); check("route_empty", 32'(bus.r_o), 32'h0);
    idle();

    // Discard under backpressure.
    do_reset();
    bus.r_c = 1; bus.ctl = 0; step();
    bus.ctl = 3; step();
    bus.r_c = 0; bus.r_i = 1; bus.d_i = 8'hAA; step();
    bus.d_i = 8'hBB;
    @(negedge clk);
    check("disc_ai", 32'(bus.a_i), 32'h1);
    check("disc_hold_ro", 32'(bus.r_o), 32'h1);
    check("disc_hold_do", 32'(bus.d_o), 32'hAA);
    step(); bus.r_i = 0;
    @(negedge clk);
    check("disc_ro", 32'(bus.r_o), 32'h1);
    check("disc_do", 32'(bus.d_o), 32'hAA);
    check("disc_cnt", 32'(drop_cnt), 32'(DROP1));
    step(); bus.a_o = 3'b001;
    @(negedge clk); check("disc_drain_ro", 32'(bus.r_o), 32'h1);
    step(); bus.a_o = 3'b000;
    @(negedge clk); check("disc_drained", 32'(bus.r_o), 32'h0);
    idle();

    // Illegal select on the K=2 instance (select 3 > discard code 2).
    do_reset();
    bus2.r_c = 1; bus2.ctl = 2'd3; step();
    bus2.r_c = 0; bus2.r_i = 1; bus2.d_i = 8'h5A;
    @(negedge clk); check("ill_ai", 32'(bus2.a_i), 32'h1); check("ill_err0", 32'(err2), 32'h0);
    step(); bus2.r_i = 0;
    @(negedge clk);
    check("ill_err", 32'(err2), 32'h1);
    check("ill_cnt", 32'(drop_cnt2), 32'(DROP1));
    check("ill_ro", 32'(bus2.r_o), 32'h0);
    step(); step();
    @(negedge clk); check("ill_sticky", 32'(err2), 32'h1);
    idle();

    // FIFO full, pop re-enables, push+pop keeps the count.
    do_reset();
    bus.r_c = 1; bus.ctl = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("full_ac_open", 32'(bus.a_c), 32'h1);
      step();
    end
    @(negedge clk); check("full_ac", 32'(bus.a_c), 32'h0);
    step();
    bus.r_i = 1;
    @(negedge clk); check("full_pop_ai", 32'(bus.a_i), 32'h1); check("full_pop_ac", 32'(bus.a_c), 32'h0);
    step();
    bus.r_i = 0; bus.r_c = 0;
    @(negedge clk); check("full_reopen", 32'(bus.a_c), 32'h1);
    step();
    bus.r_i = 1; bus.r_c = 1;
    step();
    bus.r_i = 0; bus.r_c = 0;
    @(negedge clk); check("pushpop_ac", 32'(bus.a_c), 32'h1);
    bus.r_c = 1;
    step();
    bus.r_c = 0;
    @(negedge clk); check("refull_ac", 32'(bus.a_c), 32'h0);
    idle();

    // Saturation: many discards at one per cycle.
    do_reset();
    bus.r_c = 1; bus.ctl = 3; bus.r_i = 1;
    for (int i = 0; i < 24; i++) step();
    bus.r_i = 0; bus.r_c = 0;
    @(negedge clk); check("sat_cnt", 32'(drop_cnt), 32'(SAT));
    idle();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      bus.r_i = ($urandom_range(0, 9) < 6);
      bus.d_i = 8'($urandom);
      bus.r_c = ($urandom_range(0, 1) == 1);
      bus.ctl = 2'($urandom_range(0, 3));
      bus.a_o = (i % 500 < 250) ? 3'($urandom) : 3'b111;
      step();
    end
    rst = 0;
    idle();
    step(); step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
